// File: rtl/mem_seq_pkg.sv
// Opcodes, FSM state encoding, error codes and opcode helpers shared by the
// memory access sequencer and its testbench.
package mem_seq_pkg;

  localparam logic [5:0] LW  = 6'b000000;
  localparam logic [5:0] LUB = 6'b000001;
  localparam logic [5:0] LUH = 6'b000010;
  localparam logic [5:0] LDD = 6'b000011;
  localparam logic [5:0] SW  = 6'b000100;
  localparam logic [5:0] SB  = 6'b000101;
  localparam logic [5:0] SH  = 6'b000110;
  localparam logic [5:0] SDD = 6'b000111;
  localparam logic [5:0] LSB = 6'b001001;
  localparam logic [5:0] LSH = 6'b001010;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_NEXT, S_FINISH
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_STORE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op <= SDD) || (op == LSB) || (op == LSH);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return is_legal_op(op) && !(op inside {SW, SB, SH, SDD});
  endfunction

  function automatic logic is_dword(input logic [5:0] op);
    return (op == LDD) || (op == SDD);
  endfunction

  // The RAM has no doubleword ops; each half is issued as a plain word access.
  function automatic logic [5:0] ram_op(input logic [5:0] op);
    if (op == LDD) return LW;
    if (op == SDD) return SW;
    return op;
  endfunction

  function automatic logic is_aligned(input logic [5:0] op, input logic [2:0] a);
    case (op)
      LDD, SDD:     return a == 3'b000;
      LW, SW:       return a[1:0] == 2'b00;
      LUH, SH, LSH: return a[0] == 1'b0;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_seq_sync.sv
// STAGES-deep flop synchronizer for an asynchronous level input, with a
// synchronous clear that also empties the pipeline of stale values.
module mem_seq_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_sync <= '0;
    end else begin
      r_sync <= STAGES'({r_sync, i_d});
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences one CU memory request onto the level-toggle 512x8 RAM, splitting
// doublewords into two word accesses. Define MEM_SEQ_ALIGN_CHECK_EN to reject
// misaligned requests before the RAM is touched.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic [5:0]  OpCode,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn_Hi,
  input  logic [31:0] DataIn_Lo,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [1:0]  ErrCode,
  output logic [31:0] DataOut_Hi,
  output logic [31:0] DataOut_Lo,
  output logic        Ram_Enable,
  output logic [5:0]  Ram_OpCode,
  output logic [31:0] Ram_Address,
  output logic [31:0] Ram_DataIn,
  input  logic [31:0] Ram_DataOut,
  input  logic        Ram_MFC,
  input  logic        Ram_MSET
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             r_state, w_state_nxt;
  logic [5:0]         r_op;
  logic               r_second;
  logic [31:0]        r_data_lo;
  logic [1:0]         r_errcode;
  logic [31:0]        r_dout_hi, r_dout_lo;
  logic               r_ram_en;
  logic [5:0]         r_ram_op;
  logic [31:0]        r_ram_addr, r_ram_din;
  logic [CNT_W-1:0]   r_cnt;

  logic w_mfc, w_mset, w_misalign, w_sync_clr;
  logic w_accept, w_start, w_toggle, w_load_cnt, w_capture, w_advance, w_err_we;
  logic [1:0] w_err_nxt;

  // Clearing the synchronizers on every Enable toggle guarantees that a
  // completion left high by the previous access can never be taken.
  assign w_sync_clr = Reset | w_toggle;

  mem_seq_sync #(.STAGES(SYNC_STAGES)) u_sync_mfc (
    .i_clk(Clk), .i_clr(w_sync_clr), .i_d(Ram_MFC),  .o_q(w_mfc)
  );
  mem_seq_sync #(.STAGES(SYNC_STAGES)) u_sync_mset (
    .i_clk(Clk), .i_clr(w_sync_clr), .i_d(Ram_MSET), .o_q(w_mset)
  );

`ifdef MEM_SEQ_ALIGN_CHECK_EN
  assign w_misalign = !is_aligned(OpCode, Address[2:0]);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    w_toggle    = 1'b0;
    w_load_cnt  = 1'b0;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_err_we    = 1'b0;
    w_err_nxt   = ERR_NONE;
    unique case (r_state)
      S_IDLE: if (Req) begin
        w_accept = 1'b1;
        w_err_we = 1'b1;
        if (!is_legal_op(OpCode) || w_misalign) begin
          w_err_nxt   = ERR_ILLEGAL;
          w_state_nxt = S_FINISH;
        end else begin
          w_start     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_toggle    = 1'b1;
        w_state_nxt = S_ARM;
      end
      S_ARM: begin
        w_load_cnt  = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_mset) begin
          w_err_we    = 1'b1;
          w_err_nxt   = ERR_STORE;
          w_state_nxt = S_FINISH;
        end else if (w_mfc) begin
          w_capture = is_load(r_op);
          if (is_dword(r_op) && !r_second) begin
            w_state_nxt = S_NEXT;
          end else begin
            w_err_we    = 1'b1;
            w_state_nxt = S_FINISH;
          end
        end else if (r_cnt == CNT_W'(1)) begin
          w_err_we    = 1'b1;
          w_err_nxt   = ERR_TIMEOUT;
          w_state_nxt = S_FINISH;
        end
      end
      S_NEXT: begin
        w_advance   = 1'b1;
        w_state_nxt = S_ISSUE;
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    if (Reset) begin
      r_op       <= '0;
      r_second   <= 1'b0;
      r_data_lo  <= '0;
      r_errcode  <= ERR_NONE;
      r_dout_hi  <= '0;
      r_dout_lo  <= '0;
      r_ram_en   <= 1'b0;
      r_ram_op   <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_op      <= OpCode;
        r_second  <= 1'b0;
        r_data_lo <= DataIn_Lo;
      end
      if (w_start) begin
        r_ram_op   <= ram_op(OpCode);
        r_ram_addr <= Address;
        r_ram_din  <= DataIn_Hi;
      end
      if (w_advance) begin
        r_second   <= 1'b1;
        r_ram_addr <= r_ram_addr + 32'd4;
        r_ram_din  <= r_data_lo;
      end
      if (w_toggle) r_ram_en <= ~r_ram_en;
      if (w_capture) begin
        if (r_second) r_dout_lo <= Ram_DataOut;
        else          r_dout_hi <= Ram_DataOut;
      end
      if (w_err_we) r_errcode <= w_err_nxt;
      if (w_load_cnt)            r_cnt <= CNT_W'(TIMEOUT_CYCLES);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign Busy        = r_state inside {S_ISSUE, S_ARM, S_WAIT, S_NEXT};
  assign Done        = (r_state == S_FINISH);
  assign Error       = Done && (r_errcode != ERR_NONE);
  assign ErrCode     = r_errcode;
  assign DataOut_Hi  = r_dout_hi;
  assign DataOut_Lo  = r_dout_lo;
  assign Ram_Enable  = r_ram_en;
  assign Ram_OpCode  = r_ram_op;
  assign Ram_Address = r_ram_addr;
  assign Ram_DataIn  = r_ram_din;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a behavioural level-toggle RAM
// and a scoreboard of expected completions.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

  localparam int RAM_DELAY = 2;

  logic        Clk = 1'b0, Reset = 1'b1, Req = 1'b0;
  logic [5:0]  OpCode = '0;
  logic [31:0] Address = '0, DataIn_Hi = '0, DataIn_Lo = '0;
  logic        Busy, Done, Error;
  logic [1:0]  ErrCode;
  logic [31:0] DataOut_Hi, DataOut_Lo;
  logic        Ram_Enable;
  logic [5:0]  Ram_OpCode;
  logic [31:0] Ram_Address, Ram_DataIn;
  logic [31:0] Ram_DataOut = '0;
  logic        Ram_MFC = 1'b0, Ram_MSET = 1'b0;

  mem_access_sequencer #(.TIMEOUT_CYCLES(16), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .OpCode(OpCode), .Address(Address),
    .DataIn_Hi(DataIn_Hi), .DataIn_Lo(DataIn_Lo), .Busy(Busy), .Done(Done),
    .Error(Error), .ErrCode(ErrCode), .DataOut_Hi(DataOut_Hi),
    .DataOut_Lo(DataOut_Lo), .Ram_Enable(Ram_Enable), .Ram_OpCode(Ram_OpCode),
    .Ram_Address(Ram_Address), .Ram_DataIn(Ram_DataIn),
    .Ram_DataOut(Ram_DataOut), .Ram_MFC(Ram_MFC), .Ram_MSET(Ram_MSET)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural RAM: big-endian bytes; a toggle of Enable drops MFC/MSET,
  // and RAM_DELAY cycles later the access completes (unless ram_silent).
  logic [7:0]  mem [0:511];
  logic        prev_en = 1'b0;
  int          cd = 0;
  logic [5:0]  a_op;
  logic [31:0] a_addr, a_din;
  logic [31:0] acc_addr[$];
  logic [5:0]  acc_op[$];
  int          tog_cyc = 0;
  bit          ram_silent = 1'b0;

  always @(negedge Clk) begin
    if (Ram_Enable !== prev_en) begin
      prev_en  = Ram_Enable;
      Ram_MFC  = 1'b0;
      Ram_MSET = 1'b0;
      a_op     = Ram_OpCode;
      a_addr   = Ram_Address;
      a_din    = Ram_DataIn;
      cd       = RAM_DELAY;
      tog_cyc  = cyc;
      acc_addr.push_back(Ram_Address);
      acc_op.push_back(Ram_OpCode);
    end else if (cd > 0) begin
      cd--;
      if (cd == 0 && !ram_silent) begin
        int a;
        a = int'(a_addr[8:0]);
        case (a_op)
          LW: begin
            Ram_DataOut = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
            Ram_MFC = 1'b1;
          end
          LUB: begin
            Ram_DataOut = {24'd0, mem[a]};
            Ram_MFC = 1'b1;
          end
          SW: begin
            if (a_addr[1:0] != 2'b00) Ram_MSET = 1'b1;
            else begin
              {mem[a], mem[a+1], mem[a+2], mem[a+3]} = a_din;
              Ram_MFC = 1'b1;
            end
          end
          default: Ram_MSET = 1'b1;
        endcase
      end
    end
  end

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];
  int   last_done_cyc = 0;

  task automatic do_req(input logic [5:0] op, input logic [31:0] addr, d_hi, d_lo,
                        input logic [1:0] e_err, input logic [31:0] e_hi, e_lo,
                        input string tag, output int lat);
    exp_t e;
    int   n;
    acc_addr.delete();
    acc_op.delete();
    sb.push_back('{err: e_err, hi: e_hi, lo: e_lo});
    @(negedge Clk);
    Req = 1'b1; OpCode = op; Address = addr; DataIn_Hi = d_hi; DataIn_Lo = d_lo;
    @(negedge Clk);
    Req = 1'b0;
    check({tag, " busy"}, Busy, e_err != ERR_ILLEGAL);
    n = 0;
    while (!Done && n < 200) begin
      @(negedge Clk);
      n++;
    end
    lat = n;
    last_done_cyc = cyc;
    check({tag, " done"}, Done, 1'b1);
    e = sb.pop_front();
    if (Done) begin
      check({tag, " errcode"}, ErrCode, e.err);
      check({tag, " error"}, Error, e.err != ERR_NONE);
      check({tag, " hi"}, DataOut_Hi, e.hi);
      check({tag, " lo"}, DataOut_Lo, e.lo);
      check({tag, " busy at done"}, Busy, 1'b0);
    end
    @(negedge Clk);
    check({tag, " done pulse"}, Done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic en_before;
    bit   seen;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    {mem[16], mem[17], mem[18], mem[19]} = 32'hDEADBEEF;

    repeat (3) @(negedge Clk);
    check("rst busy", Busy, 1'b0);
    check("rst done", Done, 1'b0);
    check("rst error", Error, 1'b0);
    check("rst errcode", ErrCode, 2'b00);
    check("rst ram_en", Ram_Enable, 1'b0);
    check("rst dout_hi", DataOut_Hi, 32'h0);
    check("rst ram_addr", Ram_Address, 32'h0);
    Reset = 1'b0;
    @(negedge Clk);

    do_req(LW, 32'h10, 32'h0, 32'h0, ERR_NONE, 32'hDEADBEEF, 32'h0, "lw", lat);
    check("lw toggles", acc_addr.size(), 1);
    if (acc_addr.size() == 1) begin
      check("lw ram_op", acc_op[0], 6'b000000);
      check("lw ram_addr", acc_addr[0], 32'h10);
    end

    do_req(LUB, 32'h11, 32'h0, 32'h0, ERR_NONE, 32'h000000AD, 32'h0, "lub", lat);
    if (acc_op.size() == 1) check("lub ram_op", acc_op[0], 6'b000001);

    do_req(SDD, 32'h20, 32'h11223344, 32'h55667788, ERR_NONE, 32'h000000AD, 32'h0,
           "sdd", lat);
    check("sdd toggles", acc_addr.size(), 2);
    if (acc_addr.size() == 2) begin
      check("sdd addr0", acc_addr[0], 32'h20);
      check("sdd addr1", acc_addr[1], 32'h24);
      check("sdd op0", acc_op[0], 6'b000100);
      check("sdd op1", acc_op[1], 6'b000100);
    end

    do_req(LDD, 32'h20, 32'h0, 32'h0, ERR_NONE, 32'h11223344, 32'h55667788, "ldd", lat);
    check("ldd toggles", acc_addr.size(), 2);
    if (acc_addr.size() == 2) begin
      check("ldd addr1", acc_addr[1], 32'h24);
      check("ldd op1", acc_op[1], 6'b000000);
    end

`ifdef MEM_SEQ_ALIGN_CHECK_EN
    do_req(SW, 32'h22, 32'hCAFEF00D, 32'h0, ERR_ILLEGAL, 32'h11223344, 32'h55667788,
           "sw misaligned", lat);
    check("sw misaligned toggles", acc_addr.size(), 0);
`else
    do_req(SW, 32'h22, 32'hCAFEF00D, 32'h0, ERR_STORE, 32'h11223344, 32'h55667788,
           "sw misaligned", lat);
    check("sw misaligned toggles", acc_addr.size(), 1);
`endif

    // Silent RAM: Done must come after the ARM cycle plus 16 WAIT cycles.
    ram_silent = 1'b1;
    do_req(LW, 32'h10, 32'h0, 32'h0, ERR_TIMEOUT, 32'h11223344, 32'h55667788,
           "timeout", lat);
    check("timeout cycles", last_done_cyc - tog_cyc, 17);
    ram_silent = 1'b0;

    en_before = Ram_Enable;
    do_req(6'b111111, 32'h10, 32'h0, 32'h0, ERR_ILLEGAL, 32'h11223344, 32'h55667788,
           "illegal", lat);
    check("illegal latency", lat, 0);
    check("illegal toggles", acc_addr.size(), 0);
    check("illegal ram_en", Ram_Enable, en_before);

    // Reset during WAIT of an LDD: no Done, back to idle, outputs cleared.
    acc_addr.delete();
    acc_op.delete();
    @(negedge Clk);
    Req = 1'b1; OpCode = LDD; Address = 32'h20;
    @(negedge Clk);
    Req = 1'b0;
    lat = 0;
    while (acc_addr.size() == 0 && lat < 50) begin
      @(negedge Clk);
      lat++;
    end
    check("ldd reset reached arm", acc_addr.size(), 1);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("mid reset busy", Busy, 1'b0);
    check("mid reset done", Done, 1'b0);
    check("mid reset ram_en", Ram_Enable, 1'b0);
    check("mid reset dout_hi", DataOut_Hi, 32'h0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge Clk);
      if (Done) seen = 1'b1;
    end
    check("mid reset no done", seen, 1'b0);

    do_req(LW, 32'h10, 32'h0, 32'h0, ERR_NONE, 32'hDEADBEEF, 32'h0, "lw after reset", lat);
    check("lw after reset toggles", acc_addr.size(), 1);

    check("scoreboard empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
